// File: rtl/axi_ring_buffer.sv
// axi_ring_buffer: DDR-backed sample FIFO.
// Packs a 32-bit input word stream into fixed-length AXI4 INCR write bursts
// that fill a ring region of external memory. It reads the data back with
// AXI4 read bursts and returns it as an in-order 32-bit output stream.
//
// Ports:
//   aclk, reset           clock; synchronous active-high reset
//   in_valid/in_ready/in_data      input word stream
//   out_valid/out_ready/out_data   output word stream
//   fill_words            number of words committed to the ring
//   aw*/w*/b*             AXI4 write channels (master side)
//   ar*/r*                AXI4 read channels (master side)
module axi_ring_buffer #(
   parameter logic [31:0] base_addr  = 32'h0000_0000,
   parameter int unsigned ring_words = 4096,
   parameter int unsigned burst_len  = 16
) (
   input  logic        aclk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [31:0] fill_words,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   input  logic [1:0]  bresp,
   output logic        bready,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic        rvalid,
   input  logic [31:0] rdata,
   input  logic        rlast,
   input  logic [1:0]  rresp,
   output logic        rready
);

   localparam int unsigned PW = $clog2(ring_words);
   localparam int unsigned CW = $clog2(burst_len + 1);
   localparam int unsigned BW = (burst_len > 1) ? $clog2(burst_len) : 1;
   localparam logic [CW-1:0] BURST_C   = CW'(burst_len);
   localparam logic [BW-1:0] LAST_BEAT = BW'(burst_len - 1);
   localparam logic [31:0]   RING_32   = 32'(ring_words);
   localparam logic [31:0]   BURST_32  = 32'(burst_len);
   localparam logic [PW-1:0] PTR_STEP  = PW'(burst_len);

   typedef enum logic [1:0] {W_FILL, W_ADDR, W_DATA, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

   wstate_t       wstate, wstate_nxt;
   rstate_t       rstate, rstate_nxt;
   logic [CW-1:0] wcount, ocount;
   logic [BW-1:0] wbeat, rbeat, ridx;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   wbuf [burst_len];
   logic [31:0]   rbuf [burst_len];
   logic          wr_done, rd_done;

   // Response codes and rlast are not used: the burst length is fixed.
   logic unused_inputs;
   assign unused_inputs = ^{bresp, rresp, rlast};

   // Constant AXI fields
   assign awid    = 4'd0;
   assign arid    = 4'd0;
   assign awlen   = 8'(burst_len - 1);
   assign arlen   = 8'(burst_len - 1);
   assign awsize  = 3'b010;
   assign arsize  = 3'b010;
   assign awburst = 2'b01;
   assign arburst = 2'b01;
   assign wstrb   = 4'hF;

   assign awaddr  = base_addr + 32'({wr_ptr, 2'b00});
   assign araddr  = base_addr + 32'({rd_ptr, 2'b00});
   assign wdata   = wbuf[wbeat];

   assign wr_done = (wstate == W_RESP) && bvalid;
   assign rd_done = (rstate == R_DATA) && rvalid && (rbeat == LAST_BEAT);

   // Output stream walks the read buffer from index 0 upward as ocount drains
   assign ridx      = (ocount == '0) ? '0 : BW'(BURST_C - ocount);
   assign out_valid = (ocount != '0);
   assign out_data  = rbuf[ridx];

   // Write FSM state register
   always_ff @(posedge aclk) begin
      if (reset) wstate <= W_FILL;
      else       wstate <= wstate_nxt;
   end

   // Write FSM next state and channel controls
   always_comb begin
      wstate_nxt = wstate;
      in_ready   = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      wlast      = 1'b0;
      bready     = 1'b0;
      case (wstate)
         W_FILL: begin
            in_ready = (wcount < BURST_C);
            if ((wcount == BURST_C) && ((RING_32 - fill_words) >= BURST_32))
               wstate_nxt = W_ADDR;
         end
         W_ADDR: begin
            awvalid = 1'b1;
            if (awready) wstate_nxt = W_DATA;
         end
         W_DATA: begin
            wvalid = 1'b1;
            wlast  = (wbeat == LAST_BEAT);
            if (wready && (wbeat == LAST_BEAT)) wstate_nxt = W_RESP;
         end
         W_RESP: begin
            bready = 1'b1;
            if (bvalid) wstate_nxt = W_FILL;
         end
         default: wstate_nxt = W_FILL;
      endcase
   end

   // Write staging buffer storage
   always_ff @(posedge aclk) begin
      if (in_valid && in_ready) wbuf[BW'(wcount)] <= in_data;
   end

   // Write side counters and ring pointer
   always_ff @(posedge aclk) begin
      if (reset) begin
         wcount <= '0;
         wbeat  <= '0;
         wr_ptr <= '0;
      end else begin
         if (in_valid && in_ready) wcount <= wcount + CW'(1);
         if (wvalid && wready) wbeat <= wlast ? '0 : wbeat + BW'(1);
         if (wr_done) begin
            wcount <= '0;
            wr_ptr <= wr_ptr + PTR_STEP;
         end
      end
   end

   // Read FSM state register
   always_ff @(posedge aclk) begin
      if (reset) rstate <= R_IDLE;
      else       rstate <= rstate_nxt;
   end

   // Read FSM next state and channel controls
   always_comb begin
      rstate_nxt = rstate;
      arvalid    = 1'b0;
      rready     = 1'b0;
      case (rstate)
         R_IDLE: begin
            if ((fill_words >= BURST_32) && (ocount == '0)) rstate_nxt = R_ADDR;
         end
         R_ADDR: begin
            arvalid = 1'b1;
            if (arready) rstate_nxt = R_DATA;
         end
         R_DATA: begin
            rready = 1'b1;
            if (rvalid && (rbeat == LAST_BEAT)) rstate_nxt = R_IDLE;
         end
         default: rstate_nxt = R_IDLE;
      endcase
   end

   // Read buffer storage; only written while the output side is empty
   always_ff @(posedge aclk) begin
      if (rvalid && rready) rbuf[rbeat] <= rdata;
   end

   // Read side counters, ring pointer and output occupancy
   always_ff @(posedge aclk) begin
      if (reset) begin
         rbeat  <= '0;
         rd_ptr <= '0;
         ocount <= '0;
      end else begin
         if (rvalid && rready) rbeat <= (rbeat == LAST_BEAT) ? '0 : rbeat + BW'(1);
         if (rd_done) begin
            ocount <= BURST_C;
            rd_ptr <= rd_ptr + PTR_STEP;
         end else if (out_valid && out_ready) begin
            ocount <= ocount - CW'(1);
         end
      end
   end

   // Committed-word count; simultaneous write and read completions cancel
   always_ff @(posedge aclk) begin
      if (reset) fill_words <= '0;
      else begin
         case ({wr_done, rd_done})
            2'b10:   fill_words <= fill_words + BURST_32;
            2'b01:   fill_words <= fill_words - BURST_32;
            default: fill_words <= fill_words;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_ring_buffer.sv
// Directed bench for axi_ring_buffer with a small behavioural AXI slave.
// Ring of 64 words, 16-word bursts, ring base at 0x1000.
module tb_axi_ring_buffer;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        aclk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [31:0] fill_words;
   logic [3:0]  awid, arid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rlast, rready;
   logic [3:0]  wstrb;

   int tests  = 0;
   int failed = 0;

   always #5 aclk = ~aclk;

   axi_ring_buffer #(.base_addr(BASE), .ring_words(64), .burst_len(16)) dut (
      .aclk(aclk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .fill_words(fill_words),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bresp(bresp), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rresp(rresp), .rready(rready)
   );

   // ---------------- behavioural AXI slave ----------------
   logic [31:0] mem [64];
   logic        aw_ok = 1'b1, w_ok = 1'b1, ar_ok = 1'b1;
   logic        aw_pend, s_bvalid, s_ractive;
   logic [31:0] s_waddr, s_raddr;
   int          s_wbeat, s_rbeat;
   int          wlast_err = 0, wstrb_err = 0;

   assign awready = aw_ok && !aw_pend && !s_bvalid;
   assign wready  = w_ok && aw_pend;
   assign bvalid  = s_bvalid;
   assign bresp   = 2'b00;
   assign arready = ar_ok && !s_ractive;
   assign rvalid  = s_ractive;
   assign rdata   = mem[s_raddr[7:2]];
   assign rlast   = s_ractive && (s_rbeat == 15);
   assign rresp   = 2'b00;

   always @(posedge aclk) begin
      if (reset) begin
         aw_pend <= 1'b0; s_bvalid <= 1'b0; s_ractive <= 1'b0;
         s_wbeat <= 0; s_rbeat <= 0; s_waddr <= '0; s_raddr <= '0;
      end else begin
         if (awvalid && awready) begin
            aw_pend <= 1'b1; s_waddr <= awaddr; s_wbeat <= 0;
         end
         if (wvalid && wready) begin
            mem[s_waddr[7:2]] <= wdata;
            s_waddr <= s_waddr + 32'd4;
            s_wbeat <= s_wbeat + 1;
            if (wlast !== (s_wbeat == 15)) wlast_err <= wlast_err + 1;
            if (wstrb !== 4'hF) wstrb_err <= wstrb_err + 1;
            if (s_wbeat == 15) begin aw_pend <= 1'b0; s_bvalid <= 1'b1; end
         end
         if (s_bvalid && bready) s_bvalid <= 1'b0;
         if (arvalid && arready) begin
            s_ractive <= 1'b1; s_raddr <= araddr; s_rbeat <= 0;
         end
         if (s_ractive && rready) begin
            s_raddr <= s_raddr + 32'd4;
            s_rbeat <= s_rbeat + 1;
            if (s_rbeat == 15) s_ractive <= 1'b0;
         end
      end
   end

   // ---------------- monitor (samples on the falling edge) ----------------
   logic [31:0] out_q[$], aw_q[$], ar_q[$];
   int  max_fill = 0, drop_err = 0, hdr_err = 0, w_hs = 0;
   logic aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;

   always @(negedge aclk) begin
      if (reset) begin
         aw_hold = 1'b0; w_hold = 1'b0; ar_hold = 1'b0; w_hs = 0;
      end else begin
         if (aw_hold && !awvalid) drop_err++;
         if (w_hold && !wvalid) drop_err++;
         if (ar_hold && !arvalid) drop_err++;
         aw_hold = awvalid && !awready;
         w_hold  = wvalid && !wready;
         ar_hold = arvalid && !arready;
         if (out_valid && out_ready) out_q.push_back(out_data);
         if (awvalid && awready) begin
            aw_q.push_back(awaddr);
            if (awlen !== 8'd15 || awsize !== 3'b010 || awburst !== 2'b01 || awid !== 4'd0) hdr_err++;
         end
         if (arvalid && arready) begin
            ar_q.push_back(araddr);
            if (arlen !== 8'd15 || arsize !== 3'b010 || arburst !== 2'b01 || arid !== 4'd0) hdr_err++;
         end
         if (wvalid && wready) w_hs++;
         if (int'(fill_words) > max_fill) max_fill = int'(fill_words);
      end
   end

   // Random slave/consumer stalls, applied just after the rising edge
   bit rand_mode = 1'b0;
   always @(posedge aclk) begin
      #1;
      if (rand_mode) begin
         aw_ok     = ($urandom_range(0, 3) != 0);
         w_ok      = ($urandom_range(0, 3) != 0);
         ar_ok     = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge aclk);
      reset = 1'b1; in_valid = 1'b0;
      repeat (2) @(negedge aclk);
      out_q.delete(); aw_q.delete(); ar_q.delete(); max_fill = 0;
      reset = 1'b0;
   endtask

   // Offers words first, first+1, ... until n accepted or budget expires.
   task automatic push(input int n, input logic [31:0] first, input bit gaps,
                       input int budget, output int acc);
      int  cyc;
      logic take;
      cyc = 0; acc = 0;
      while (acc < n && cyc < budget) begin
         in_valid = (gaps && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
         in_data  = first + 32'(acc);
         take     = in_valid && in_ready;
         @(negedge aclk);
         cyc++;
         if (take) acc++;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input int n, input int budget);
      int cyc;
      cyc = 0;
      while (out_q.size() < n && cyc < budget) begin
         @(negedge aclk);
         cyc++;
      end
      check("output word count", 32'(out_q.size()), 32'(n));
   endtask

   task automatic check_words(input string tag, input int n, input logic [31:0] first);
      logic [31:0] obs;
      for (int i = 0; i < n; i++) begin
         obs = (i < out_q.size()) ? out_q[i] : 32'hDEAD_BEEF;
         check($sformatf("%s word %0d", tag, i), obs, first + 32'(i));
      end
   endtask

   // ---------------- directed sequence ----------------
   int acc;
   int bad;

   initial begin
      do_reset();

      // Reset state
      check("rst awvalid", 32'(awvalid), 32'd0);
      check("rst wvalid", 32'(wvalid), 32'd0);
      check("rst wlast", 32'(wlast), 32'd0);
      check("rst bready", 32'(bready), 32'd0);
      check("rst arvalid", 32'(arvalid), 32'd0);
      check("rst rready", 32'(rready), 32'd0);
      check("rst fill", fill_words, 32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);

      // Single burst
      out_ready = 1'b1;
      push(16, 32'd0, 1'b0, 200, acc);
      check("s1 accepted", 32'(acc), 32'd16);
      wait_out(16, 300);
      check_words("s1", 16, 32'd0);
      check("s1 aw count", 32'(aw_q.size()), 32'd1);
      check("s1 aw addr", (aw_q.size() > 0) ? aw_q[0] : 32'hDEAD_BEEF, BASE);
      check("s1 ar addr", (ar_q.size() > 0) ? ar_q[0] : 32'hDEAD_BEEF, BASE);
      check("s1 peak fill", 32'(max_fill), 32'd16);
      check("s1 final fill", fill_words, 32'd0);
      check("s1 out_valid idle", 32'(out_valid), 32'd0);

      // Sequential addressing over four bursts
      do_reset();
      out_ready = 1'b1;
      push(64, 32'd100, 1'b0, 600, acc);
      wait_out(64, 600);
      check_words("seq", 64, 32'd100);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("seq aw %0d", i), (aw_q.size() > i) ? aw_q[i] : 32'hDEAD_BEEF,
               BASE + 32'(64 * i));
         check($sformatf("seq ar %0d", i), (ar_q.size() > i) ? ar_q[i] : 32'hDEAD_BEEF,
               BASE + 32'(64 * i));
      end

      // Full ring with output backpressure
      do_reset();
      out_ready = 1'b0;
      push(200, 32'd1000, 1'b0, 400, acc);
      check("bp accepted", 32'(acc), 32'd96);
      check("bp fill", fill_words, 32'd64);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out_data head", out_data, 32'd1000);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp aw count", 32'(aw_q.size()), 32'd5);
      check("bp wrap aw addr", (aw_q.size() > 4) ? aw_q[4] : 32'hDEAD_BEEF, BASE);
      out_ready = 1'b1;
      wait_out(96, 1500);
      check_words("bp", 96, 32'd1000);
      check("bp aw after drain", (aw_q.size() > 5) ? aw_q[5] : 32'hDEAD_BEEF, BASE + 32'h40);
      check("bp peak fill", 32'(max_fill), 32'd64);

      // Random stalls on every handshake
      do_reset();
      rand_mode = 1'b1;
      push(2000, 32'd7000, 1'b1, 30000, acc);
      check("rnd accepted", 32'(acc), 32'd2000);
      wait_out(2000, 8000);
      @(negedge aclk);
      rand_mode = 1'b0;
      aw_ok = 1'b1; w_ok = 1'b1; ar_ok = 1'b1; out_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 2000; i++)
         if (i >= out_q.size() || out_q[i] !== 32'd7000 + 32'(i)) bad++;
      check("rnd word mismatches", 32'(bad), 32'd0);
      check("rnd fill within ring", 32'(max_fill <= 64), 32'd1);

      // Reset in the middle of a write burst
      do_reset();
      out_ready = 1'b0;
      push(16, 32'd300, 1'b0, 100, acc);
      bad = 0;
      while (!(wvalid && w_hs == 5) && bad < 200) begin
         @(negedge aclk);
         bad++;
      end
      check("mid reached beat 5", 32'(w_hs), 32'd5);
      reset = 1'b1;
      @(negedge aclk);
      check("mid awvalid", 32'(awvalid), 32'd0);
      check("mid wvalid", 32'(wvalid), 32'd0);
      check("mid arvalid", 32'(arvalid), 32'd0);
      check("mid bready", 32'(bready), 32'd0);
      check("mid fill", fill_words, 32'd0);
      check("mid in_ready", 32'(in_ready), 32'd1);
      out_q.delete(); aw_q.delete(); ar_q.delete();
      reset = 1'b0;
      @(negedge aclk);
      out_ready = 1'b1;
      push(16, 32'd500, 1'b0, 200, acc);
      wait_out(16, 300);
      check_words("mid", 16, 32'd500);
      check("mid aw addr", (aw_q.size() > 0) ? aw_q[0] : 32'hDEAD_BEEF, BASE);

      // Partial burst stays staged until completed
      do_reset();
      out_ready = 1'b1;
      push(10, 32'd200, 1'b0, 100, acc);
      repeat (40) @(negedge aclk);
      check("part no aw", 32'(aw_q.size()), 32'd0);
      check("part out_valid", 32'(out_valid), 32'd0);
      check("part no output", 32'(out_q.size()), 32'd0);
      push(6, 32'd210, 1'b0, 100, acc);
      wait_out(16, 300);
      check_words("part", 16, 32'd200);
      check("part aw count", 32'(aw_q.size()), 32'd1);

      // Protocol monitors accumulated over the whole run
      check("valid dropped before handshake", 32'(drop_err), 32'd0);
      check("wlast placement", 32'(wlast_err), 32'd0);
      check("wstrb value", 32'(wstrb_err), 32'd0);
      check("burst header fields", 32'(hdr_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
